serial_frame_recv: RTL and testbench
====================================

Name: serial_frame_recv

Overview:
- Receive end of the 3-wire DAC frame interface (clk, sync, din) driven by the `send` block.
- Deserializes one frame (HDR_W-bit header, then DATA_W-bit sample) into parallel words and pulses `valid` when the frame is complete.
- Flags truncated frames.
- Used as the on-chip loopback checker for the ultrasound drive path; also the front end for any peer FPGA that consumes the same frame.

Parameters:
HDR_W, 8, header/command width in bits
DATA_W, 16, sample width in bits
FRAME_W, HDR_W+DATA_W (24), bits per frame; derived, not overridden
CNT_W, 5, bit-counter width; must hold FRAME_W

Ports:
clk  in  1  system clock; same clock that drives the sender; all sampling on rising edge
rst  in  1  asynchronous, active-high reset
sync  in  1  frame strobe, active low; low for the whole frame
din  in  1  serial data, MSB first: header[HDR_W-1] first, data[0] last
header_out  out  HDR_W  header of last good frame
data_out  out  DATA_W  data of last good frame
valid  out  1  one-cycle pulse: a good frame has just been captured
frame_err  out  1  one-cycle pulse: sync rose before FRAME_W bits were received
busy  out  1  high while a frame is being shifted in (state SHIFT)
frame_cnt  out  16  count of good frames; wraps at 0xFFFF -> 0

Behaviour:
Reset
- `rst`=1, asynchronous: state=IDLE, shift register=0, bit count=0.
- All outputs 0: header_out, data_out, valid, frame_err, busy, frame_cnt.
- Reset mid-frame discards the partial frame. No valid or frame_err is generated for it.

Sampling
- On every rising clk edge where sync=0 and the state accepts bits, `din` is shifted in: shreg <= {shreg[FRAME_W-2:0], din}.
- No input synchronizer; sync and din are in the clk domain.

State machine
- IDLE
  - sync=1: stay in IDLE.
  - sync=0: sample bit 1, cnt=1, go to SHIFT.
- SHIFT (busy=1)
  - sync=0 and cnt<FRAME_W-1: sample, cnt++.
  - sync=0 and cnt=FRAME_W-1: sample the last bit.
    - On that same edge: header_out <= frame[FRAME_W-1:DATA_W], data_out <= frame[DATA_W-1:0], valid=1 for that cycle, frame_cnt++.
    - Go to HOLD.
  - sync=1 (cnt in 1..FRAME_W-1): frame_err=1 for one cycle, cnt=0, go to IDLE. header_out, data_out and frame_cnt are unchanged.
- HOLD
  - sync=0: extra bits are ignored. No error, no new frame.
  - sync=1: go to IDLE.
  - At least one sync=1 cycle is therefore required between frames.

Output timing
- Latency: valid is visible in the cycle after the edge that samples the last bit.
- header_out and data_out hold their values until the next good frame.
- valid and frame_err are never high in the same cycle.
- busy=0 in IDLE and HOLD.
- frame_cnt wraps from 0xFFFF to 0x0000 with no flag.

Back-to-back frames
- sync low at the first edge after the HOLD->IDLE transition starts a new frame immediately.
- Minimum frame period: FRAME_W+1 clocks.

Test Plan:
- Nominal frame: after reset, drive sync low for 24 clks with header 8'b00010110 then data 16'b1010101010101010, MSB first. Required: header_out=8'h16, data_out=16'hAAAA; valid high exactly 1 cycle, after the 24th sampling edge; frame_cnt=1; frame_err=0.
- Truncated frame: sync low for 10 bits, then high. Required: frame_err one-cycle pulse; valid=0; header_out/data_out keep their previous values (8'h16/16'hAAAA); frame_cnt unchanged; busy drops.
- Overlong sync: sync low for 30 clks with header 8'h3C, data 16'h1234. Required: exactly one valid; outputs 8'h3C/16'h1234; the 6 extra bits are ignored; no frame_err.
- Back-to-back frames: frame 8'h01/16'hFFFF, one sync-high cycle, then frame 8'h80/16'h0001. Required: two valid pulses 25 clks apart; final outputs 8'h80/16'h0001; frame_cnt=2.
- Reset mid-frame: assert rst asynchronously (between edges) after bit 12. Required: all outputs 0 immediately; no valid/frame_err afterwards; the next full frame 8'h16/16'h5555 is received correctly.
- Counter wrap: preload by running 65536 good frames (or force frame_cnt=16'hFFFF). Required: the next good frame gives frame_cnt=0 with valid asserted normally.

Source files
------------

// File: rtl/serial_frame_recv_if.sv
// Signal bundle for the 3-wire frame receiver: serial input side, parallel result side,
// plus a frame-counter preset and the FSM state for observation.
interface serial_frame_recv_if #(
  parameter int HDR_W  = 8,
  parameter int DATA_W = 16
);
  // valid and frame_err are single-cycle strobes with no backpressure: the consumer
  // must take header_out/data_out/frame_cnt in the cycle valid is high (they also hold
  // until the next good frame). There is no ready; the sender is never stalled.
  logic              sync;
  logic              din;
  logic              cnt_load;
  logic [15:0]       cnt_load_val;
  logic [HDR_W-1:0]  header_out;
  logic [DATA_W-1:0] data_out;
  logic              valid;
  logic              frame_err;
  logic              busy;
  logic [15:0]       frame_cnt;
  logic [1:0]        state_dbg;

  modport master (
    output sync, din, cnt_load, cnt_load_val,
    input  header_out, data_out, valid, frame_err, busy, frame_cnt, state_dbg
  );

  modport slave (
    input  sync, din, cnt_load, cnt_load_val,
    output header_out, data_out, valid, frame_err, busy, frame_cnt, state_dbg
  );
endinterface

// File: rtl/serial_frame_recv.sv
// Receive end of the clk/sync/din DAC frame link: deserializes header+sample frames,
// strobes valid on good frames and frame_err on truncated ones, counts good frames.
module serial_frame_recv #(
  parameter int HDR_W  = 8,
  parameter int DATA_W = 16,
  parameter int CNT_W  = 5
) (
  input  logic             clk,
  input  logic             rst,
  serial_frame_recv_if.slave bus
);
  localparam int FRAME_W = HDR_W + DATA_W;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_W - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  state_t              state_q, state_d;
  // The final bit goes straight from din into the output words, so only
  // FRAME_W-1 bits ever need to be stored.
  logic [FRAME_W-2:0]  shreg_q, shreg_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [HDR_W-1:0]    header_q, header_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                valid_q, valid_d;
  logic                err_q, err_d;
  logic [15:0]         frame_cnt_q, frame_cnt_d;
  logic [FRAME_W-1:0]  shifted;

  assign shifted = {shreg_q, bus.din};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      shreg_q     <= '0;
      cnt_q       <= '0;
      header_q    <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      err_q       <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      cnt_q       <= cnt_d;
      header_q    <= header_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      err_q       <= err_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    shreg_d     = shreg_q;
    cnt_d       = cnt_q;
    header_d    = header_q;
    data_d      = data_q;
    valid_d     = 1'b0;
    err_d       = 1'b0;
    frame_cnt_d = frame_cnt_q;

    case (state_q)
      S_IDLE: begin
        if (!bus.sync) begin
          shreg_d = shifted[FRAME_W-2:0];
          cnt_d   = CNT_W'(1);
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (!bus.sync) begin
          shreg_d = shifted[FRAME_W-2:0];
          if (cnt_q == LAST_CNT) begin
            header_d    = shifted[FRAME_W-1:DATA_W];
            data_d      = shifted[DATA_W-1:0];
            valid_d     = 1'b1;
            frame_cnt_d = frame_cnt_q + 16'd1;
            cnt_d       = '0;
            state_d     = S_HOLD;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end else begin
          err_d   = 1'b1;
          cnt_d   = '0;
          state_d = S_IDLE;
        end
      end
      S_HOLD: begin
        // Bits past the frame end are dropped until sync returns high.
        if (bus.sync) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Host preset of the good-frame counter takes priority over the increment.
    if (bus.cnt_load) frame_cnt_d = bus.cnt_load_val;
  end

  assign bus.header_out = header_q;
  assign bus.data_out   = data_q;
  assign bus.valid      = valid_q;
  assign bus.frame_err  = err_q;
  assign bus.busy       = (state_q == S_SHIFT);
  assign bus.frame_cnt  = frame_cnt_q;
  assign bus.state_dbg  = state_q;
endmodule

// File: tb/tb_serial_frame_recv.sv
// Bench for serial_frame_recv: drives frames MSB first, scoreboards good frames
// through an expected queue and checks strobes, latency and counter behaviour.
module tb_serial_frame_recv;
  localparam int HDR_W  = 8;
  localparam int DATA_W = 16;
  localparam int EXP_W  = HDR_W + DATA_W + 16;

  logic clk;
  logic rst;
  int   tests_run;
  int   fails;
  int   cyc;
  int   valid_seen;
  int   err_seen;
  int   last_valid_cyc;
  int   prev_valid_cyc;
  int   last_drive_cyc;
  logic [15:0] model_cnt;
  logic [EXP_W-1:0] exp_q[$];

  serial_frame_recv_if #(.HDR_W(HDR_W), .DATA_W(DATA_W)) bus ();

  serial_frame_recv #(.HDR_W(HDR_W), .DATA_W(DATA_W), .CNT_W(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc++;

  // output monitor / scoreboard
  always @(negedge clk) begin
    if (bus.valid === 1'b1) begin
      logic [EXP_W-1:0] exp_v;
      logic [EXP_W-1:0] act_v;
      valid_seen++;
      prev_valid_cyc = last_valid_cyc;
      last_valid_cyc = cyc;
      act_v = {bus.header_out, bus.data_out, bus.frame_cnt};
      tests_run++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL sb_unexpected_valid: got %h, required no valid", act_v);
      end else begin
        exp_v = exp_q.pop_front();
        if (act_v !== exp_v) begin
          fails++;
          $display("FAIL sb_frame: got hdr/data/cnt %h, required %h", act_v, exp_v);
        end
      end
    end
    if (bus.frame_err === 1'b1) err_seen++;
    if (bus.valid === 1'b1 && bus.frame_err === 1'b1) begin
      fails++;
      $display("FAIL valid_err_overlap: got both 1, required not both");
    end
  end

  // driver tasks
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bus.sync = 1'b1;
      bus.din  = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic drive_frame(input logic [HDR_W-1:0] hdr, input logic [DATA_W-1:0] data,
                             input int nbits);
    logic [HDR_W+DATA_W-1:0] fr;
    fr = {hdr, data};
    if (nbits >= HDR_W + DATA_W) begin
      model_cnt = model_cnt + 16'd1;
      exp_q.push_back({hdr, data, model_cnt});
    end
    for (int i = 0; i < nbits; i++) begin
      @(negedge clk);
      bus.sync = 1'b0;
      if (i < HDR_W + DATA_W) bus.din = fr[HDR_W+DATA_W-1-i];
      else                    bus.din = 1'($urandom_range(0, 1));
      if (i == HDR_W + DATA_W - 1) last_drive_cyc = cyc;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst      = 1'b1;
    bus.sync = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst       = 1'b0;
    model_cnt = 16'd0;
  endtask

  task automatic check_outputs(input string name, input logic [HDR_W-1:0] hdr,
                               input logic [DATA_W-1:0] data, input logic [15:0] cnt);
    tests_run++;
    if ({bus.header_out, bus.data_out, bus.frame_cnt} !== {hdr, data, cnt}) begin
      fails++;
      $display("FAIL %s: got %h/%h/%h, required %h/%h/%h", name, bus.header_out,
               bus.data_out, bus.frame_cnt, hdr, data, cnt);
    end
  endtask

  // scenarios
  task automatic test_reset();
    #3;
    tests_run++;
    if ({bus.header_out, bus.data_out, bus.valid, bus.frame_err, bus.busy, bus.frame_cnt} !== '0) begin
      fails++;
      $display("FAIL reset_outputs: got %h/%h v%b e%b b%b c%h, required all 0", bus.header_out,
               bus.data_out, bus.valid, bus.frame_err, bus.busy, bus.frame_cnt);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_nominal();
    int v0, e0;
    v0 = valid_seen; e0 = err_seen;
    drive_frame(8'b00010110, 16'b1010101010101010, 24);
    idle(3);
    tests_run++;
    if (valid_seen - v0 !== 1 || err_seen - e0 !== 0) begin
      fails++;
      $display("FAIL nominal_pulses: got valid %0d err %0d, required 1 0", valid_seen - v0, err_seen - e0);
    end
    tests_run++;
    if (last_valid_cyc !== last_drive_cyc + 1) begin
      fails++;
      $display("FAIL nominal_latency: got cycle %0d, required %0d", last_valid_cyc, last_drive_cyc + 1);
    end
    check_outputs("nominal_out", 8'h16, 16'hAAAA, 16'd1);
  endtask

  task automatic test_truncated();
    int v0, e0;
    v0 = valid_seen; e0 = err_seen;
    drive_frame(8'hF0, 16'h0F0F, 10);
    @(negedge clk);
    tests_run++;
    if (bus.busy !== 1'b1) begin
      fails++;
      $display("FAIL trunc_busy_mid: got %b, required 1", bus.busy);
    end
    bus.sync = 1'b1;
    idle(3);
    tests_run++;
    if (err_seen - e0 !== 1 || valid_seen - v0 !== 0 || bus.busy !== 1'b0) begin
      fails++;
      $display("FAIL trunc_pulses: got err %0d valid %0d busy %b, required 1 0 0",
               err_seen - e0, valid_seen - v0, bus.busy);
    end
    check_outputs("trunc_hold", 8'h16, 16'hAAAA, 16'd1);
  endtask

  task automatic test_overlong();
    int v0, e0;
    v0 = valid_seen; e0 = err_seen;
    drive_frame(8'h3C, 16'h1234, 30);
    idle(3);
    tests_run++;
    if (valid_seen - v0 !== 1 || err_seen - e0 !== 0) begin
      fails++;
      $display("FAIL overlong_pulses: got valid %0d err %0d, required 1 0", valid_seen - v0, err_seen - e0);
    end
    check_outputs("overlong_out", 8'h3C, 16'h1234, model_cnt);
  endtask

  task automatic test_back_to_back();
    int v0;
    do_reset();
    v0 = valid_seen;
    drive_frame(8'h01, 16'hFFFF, 24);
    idle(1);
    drive_frame(8'h80, 16'h0001, 24);
    idle(3);
    tests_run++;
    if (valid_seen - v0 !== 2 || last_valid_cyc - prev_valid_cyc !== 25) begin
      fails++;
      $display("FAIL b2b_spacing: got %0d pulses %0d apart, required 2 25 apart",
               valid_seen - v0, last_valid_cyc - prev_valid_cyc);
    end
    check_outputs("b2b_out", 8'h80, 16'h0001, 16'd2);
  endtask

  task automatic test_reset_mid_frame();
    int v0, e0;
    drive_frame(8'hAB, 16'hCDEF, 12);
    #2;
    rst      = 1'b1;
    bus.sync = 1'b1;
    #1;
    tests_run++;
    if ({bus.header_out, bus.data_out, bus.valid, bus.frame_err, bus.busy, bus.frame_cnt} !== '0) begin
      fails++;
      $display("FAIL midrst_outputs: got %h/%h v%b e%b b%b c%h, required all 0", bus.header_out,
               bus.data_out, bus.valid, bus.frame_err, bus.busy, bus.frame_cnt);
    end
    v0 = valid_seen; e0 = err_seen;
    @(negedge clk);
    @(negedge clk);
    rst       = 1'b0;
    model_cnt = 16'd0;
    idle(4);
    tests_run++;
    if (valid_seen - v0 !== 0 || err_seen - e0 !== 0) begin
      fails++;
      $display("FAIL midrst_quiet: got valid %0d err %0d, required 0 0", valid_seen - v0, err_seen - e0);
    end
    drive_frame(8'h16, 16'h5555, 24);
    idle(3);
    check_outputs("midrst_next", 8'h16, 16'h5555, 16'd1);
  endtask

  task automatic test_counter_wrap();
    int v0;
    @(negedge clk);
    bus.cnt_load     = 1'b1;
    bus.cnt_load_val = 16'hFFFF;
    @(negedge clk);
    bus.cnt_load = 1'b0;
    model_cnt    = 16'hFFFF;
    tests_run++;
    if (bus.frame_cnt !== 16'hFFFF) begin
      fails++;
      $display("FAIL wrap_preload: got %h, required ffff", bus.frame_cnt);
    end
    v0 = valid_seen;
    drive_frame(8'h5A, 16'hA5A5, 24);
    idle(3);
    tests_run++;
    if (valid_seen - v0 !== 1) begin
      fails++;
      $display("FAIL wrap_valid: got %0d pulses, required 1", valid_seen - v0);
    end
    check_outputs("wrap_out", 8'h5A, 16'hA5A5, 16'h0000);
  endtask

  task automatic test_random();
    int v0, e0, exp_v, exp_e, len;
    v0 = valid_seen; e0 = err_seen;
    exp_v = 0; exp_e = 0;
    for (int k = 0; k < 8; k++) begin
      len = $urandom_range(3, 30);
      if (len >= 24) exp_v++;
      else           exp_e++;
      drive_frame(8'($urandom), 16'($urandom), len);
      idle($urandom_range(1, 3));
    end
    idle(2);
    tests_run++;
    if (valid_seen - v0 !== exp_v || err_seen - e0 !== exp_e) begin
      fails++;
      $display("FAIL random_pulses: got valid %0d err %0d, required %0d %0d",
               valid_seen - v0, err_seen - e0, exp_v, exp_e);
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.sync = 1'b1;
    bus.din = 1'b0;
    bus.cnt_load = 1'b0;
    bus.cnt_load_val = 16'h0000;
    tests_run = 0; fails = 0; cyc = 0;
    valid_seen = 0; err_seen = 0;
    last_valid_cyc = 0; prev_valid_cyc = 0; last_drive_cyc = 0;
    model_cnt = 16'd0;

    test_reset();
    test_nominal();
    test_truncated();
    test_overlong();
    test_back_to_back();
    test_reset_mid_frame();
    test_counter_wrap();
    test_random();

    tests_run++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL sb_leftover: got %0d pending frames, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end
endmodule
